// File: rtl/tas_pkt_tx_if.sv
// tas_pkt_tx_if: payload byte handshake and serial link outputs of the packet transmitter.
interface tas_pkt_tx_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       serial_data;
  logic       data_ena;
  logic       busy;
  logic       pkt_done;
  modport master (output byte_in, byte_valid, input byte_ready, serial_data, data_ena, busy, pkt_done);
  modport slave  (input byte_in, byte_valid, output byte_ready, serial_data, data_ena, busy, pkt_done);
endinterface

// File: rtl/tas_pkt_tx.sv
// tas_pkt_tx: collects PAY_BYTES payload bytes, then shifts HEADER plus payload out MSB-first
// with data_ena high, followed by GAP_CYCLES idle cycles.
module tas_pkt_tx #(
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter int         PAY_BYTES  = 4,
  parameter int         GAP_CYCLES = 4
) (
  input logic           clk_2,
  input logic           reset_n,
  tas_pkt_tx_if.slave   bus
);
  localparam logic [6:0] LAST_BIT  = 7'(8 * (PAY_BYTES + 1) - 1);
  localparam logic [6:0] LAST_GAP  = 7'(GAP_CYCLES - 1);
  localparam logic [3:0] LAST_BYTE = 4'(PAY_BYTES - 1);
  typedef enum logic [1:0] {LOAD, SEND, GAP} state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] buf_q [8];
  logic [7:0] buf_d [8];
  logic       ser_q, ser_d, ena_q, ena_d, busy_q, busy_d, done_q, done_d;
  logic       accept;
  assign bus.byte_ready  = (state_q == LOAD) && (cnt_q < 4'(PAY_BYTES));
  assign accept          = bus.byte_ready && bus.byte_valid;
  assign bus.serial_data = ser_q;
  assign bus.data_ena    = ena_q;
  assign bus.busy        = busy_q;
  assign bus.pkt_done    = done_q;
  // bit_q doubles as the gap-cycle counter while in GAP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    if (accept) begin
      buf_d[cnt_q[2:0]] = bus.byte_in;
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == LAST_BYTE) begin
        state_d = SEND;
        bit_d   = 7'd0;
        sh_d    = HEADER;
      end
    end else if (state_q == SEND) begin
      if (bit_q == LAST_BIT) begin
        state_d = GAP;
        bit_d   = 7'd0;
        done_d  = 1'b1;
      end else begin
        bit_d = bit_q + 7'd1;
        sh_d  = (bit_q[2:0] == 3'd7) ? buf_q[bit_q[5:3]] : {sh_q[6:0], 1'b0};
      end
    end else if (state_q == GAP) begin
      state_d = (bit_q == LAST_GAP) ? LOAD : GAP;
      cnt_d   = (bit_q == LAST_GAP) ? 4'd0 : cnt_q;
      bit_d   = (bit_q == LAST_GAP) ? 7'd0 : bit_q + 7'd1;
    end
    ena_d  = (state_d == SEND);
    ser_d  = ena_d & sh_d[7];
    busy_d = (state_d != LOAD);
  end
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      buf_q   <= '{default: '0};
      ser_q   <= 1'b0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      buf_q   <= buf_d;
      ser_q   <= ser_d;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_tas_pkt_tx.sv
// tb_tas_pkt_tx: directed and random packets checked every cycle against a queue-of-future-outputs model.
module tb_tas_pkt_tx;
  localparam logic [7:0] HDR = 8'hA5;
  localparam int P = 4;
  localparam int G = 4;
  typedef struct packed {logic ena; logic ser; logic busy; logic done;} o_t;
  logic clk_2 = 1'b0;
  logic reset_n = 1'b1;
  int vec = 0, miss = 0;
  tas_pkt_tx_if bus ();
  tas_pkt_tx #(.HEADER(HDR), .PAY_BYTES(P), .GAP_CYCLES(G)) dut (.clk_2(clk_2), .reset_n(reset_n), .bus(bus));
  always #5 clk_2 = ~clk_2;
  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    vec++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction
  // Model: q holds the outputs for the current and all future cycles of a packet; empty means loading.
  o_t q[$];
  logic [7:0] pay[$];
  always @(posedge clk_2 or negedge reset_n) begin
    logic [8*(P+1)-1:0] pk;
    if (!reset_n) begin
      q.delete();
      pay.delete();
    end else if (q.size() != 0) begin
      void'(q.pop_front());
    end else if (bus.byte_valid === 1'b1) begin
      pay.push_back(bus.byte_in);
      if (pay.size() == P) begin
        pk = {{(8*P){1'b0}}, HDR};
        foreach (pay[k]) pk = (pk << 8) | {{(8*P){1'b0}}, pay[k]};
        for (int i = 8*(P+1)-1; i >= 0; i--) q.push_back('{ena: 1'b1, ser: pk[i], busy: 1'b1, done: 1'b0});
        for (int g = 0; g < G; g++) q.push_back('{ena: 1'b0, ser: 1'b0, busy: 1'b1, done: (g == 0)});
        pay.delete();
      end
    end
  end
  always @(negedge clk_2) begin
    o_t e;
    e = (q.size() != 0) ? q[0] : '0;
    chk("cycle rdy/ena/ser/busy/done",
        {59'd0, bus.byte_ready, bus.data_ena, bus.serial_data, bus.busy, bus.pkt_done},
        {59'd0, q.size() == 0, e});
  end
  // Packet capture and gap measurement
  logic [8*(P+1)-1:0] rx_sh, pkt;
  int rx_n = 0, pkt_len = 0, npkt = 0, low_n = 0, gap_seen = 0;
  always @(negedge clk_2) begin
    if (!reset_n) begin
      rx_n = 0;
      low_n = 0;
    end else if (bus.data_ena) begin
      if (rx_n == 0) gap_seen = low_n;
      rx_sh = {rx_sh[8*(P+1)-2:0], bus.serial_data};
      rx_n++;
      low_n = 0;
    end else begin
      if (rx_n > 0) begin
        pkt = rx_sh;
        pkt_len = rx_n;
        npkt++;
      end
      rx_n = 0;
      low_n++;
    end
  end
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk_2);
      acc = bus.byte_ready;
      @(posedge clk_2);
      #1;
    end
    if (!acc) chk("byte accept timeout", 0, 1);
  endtask
  task automatic idle(input int n);
    bus.byte_valid = 1'b0;
    repeat (n) @(posedge clk_2);
    #1;
  endtask
  task automatic wait_pkt(input int after);
    int i;
    for (i = 0; i < 400 && npkt <= after; i++) begin
      @(negedge clk_2);
      #1;
    end
    if (npkt <= after) chk("packet wait timeout", 0, 1);
  endtask
  task automatic do_reset();
    bus.byte_valid = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk_2);
    #1 reset_n = 1'b1;
    @(posedge clk_2);
    #1;
  endtask
  initial begin
    logic [7:0] b2, b3;
    logic [7:0] r[4];
    int n0;
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk_2);
    #1 reset_n = 1'b1;
    @(negedge clk_2);
    chk("idle serial_data", bus.serial_data, 0);
    chk("idle data_ena", bus.data_ena, 0);
    chk("idle busy", bus.busy, 0);
    chk("idle byte_ready", bus.byte_ready, 1);
    @(posedge clk_2);
    #1;
    // basic packet
    n0 = npkt;
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    idle(0);
    wait_pkt(n0);
    chk("basic stream", pkt, 40'hA512345678);
    chk("basic ena length", pkt_len, 40);
    chk("basic header bits", pkt[39:32], 8'hA5);
    idle(G + 2);
    // stalled source
    b2 = 8'($urandom);
    b3 = 8'($urandom);
    n0 = npkt;
    send_byte(8'hFF); idle(10);
    send_byte(8'h00); idle(10);
    send_byte(b2); idle(10);
    chk("no send before 4th byte", bus.data_ena, 0);
    send_byte(b3); idle(0);
    wait_pkt(n0);
    chk("stalled stream", pkt, {8'hA5, 8'hFF, 8'h00, b2, b3});
    idle(G + 2);
    // backpressure
    n0 = npkt;
    bus.byte_in = 8'h3C;
    bus.byte_valid = 1'b1;
    wait_pkt(n0 + 1);
    chk("backpressure 2nd stream", pkt, 40'hA53C3C3C3C);
    do_reset();
    // back-to-back
    n0 = npkt;
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    idle(0);
    wait_pkt(n0 + 1);
    chk("b2b 2nd stream", pkt, 40'hA505060708);
    chk("b2b gap cycles", gap_seen, G + P);
    idle(G + 2);
    // reset mid-SEND at bit 17
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    idle(0);
    for (int i = 0; i < 100 && rx_n < 17; i++) begin
      @(negedge clk_2);
      #1;
    end
    chk("reached bit 17", rx_n, 17);
    #2 reset_n = 1'b0;
    #1;
    chk("async abort data_ena", bus.data_ena, 0);
    chk("async abort busy", bus.busy, 0);
    repeat (2) @(posedge clk_2);
    #1 reset_n = 1'b1;
    @(posedge clk_2);
    #1;
    n0 = npkt;
    foreach (r[k]) begin
      r[k] = 8'($urandom);
      send_byte(r[k]);
    end
    idle(0);
    wait_pkt(n0);
    chk("post-reset stream", pkt, {8'hA5, r[0], r[1], r[2], r[3]});
    // random traffic
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < P; k++) begin
        send_byte(8'($urandom));
        idle($urandom_range(0, 3));
      end
    end
    idle(60);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/tas_pkt_tx.md
Name: tas_pkt_tx

Overview:
- Serial packet transmitter: the sending end of the serial_data/data_ena temperature link.
- Collects PAY_BYTES temperature bytes over a valid/ready byte interface and prepends a fixed header byte.
- Shifts the packet out MSB-first, one bit per clk_2 cycle, with data_ena high for the whole packet.
- Drives the averaging receiver's serial inputs in system benches and in the sensor-side FPGA build.

Parameters:
HEADER, 8'hA5, header byte sent first in every packet
PAY_BYTES, 4, payload bytes per packet (1..8)
GAP_CYCLES, 4, idle cycles with data_ena low between packets (>=1)

Ports:
clk_2  input  1  2 MHz clock; only clock in the block
reset_n  input  1  asynchronous active-low reset
byte_in  input  8  payload byte
byte_valid  input  1  byte_in is valid this cycle
byte_ready  output  1  block accepts byte_in this cycle
serial_data  output  1  serial bit stream, MSB first
data_ena  output  1  high while packet bits are on serial_data
busy  output  1  high in SEND and GAP
pkt_done  output  1  one-cycle pulse after the last bit of a packet

Behaviour:
- One clock domain (clk_2). Reset is asynchronous, active-low.
- All outputs are registered except byte_ready, which is decoded from state and count.
- Reset values:
  - serial_data=0, data_ena=0, busy=0, pkt_done=0.
  - state=LOAD, byte count=0, bit count=0, payload buffer cleared.
- FSM states: LOAD, SEND, GAP.
- LOAD:
  - byte_ready = 1 while count < PAY_BYTES.
  - A byte is accepted on a rising edge where byte_valid && byte_ready. It is written to buffer[count] and count increments.
  - On the edge that accepts byte PAY_BYTES-1: state -> SEND, bit count = 0, shift register loaded with HEADER.
  - byte_valid with byte_ready low is ignored; no data is lost because the source must hold it.
  - Partial packets wait indefinitely. There is no timeout.
- SEND:
  - Lasts exactly 8*(PAY_BYTES+1) cycles.
  - data_ena=1 and serial_data = current MSB of the shift register.
  - Sequence: HEADER, then buffer[0] .. buffer[PAY_BYTES-1], each MSB first. No gaps between bytes.
  - byte_ready = 0.
  - After the last bit (LSB of the final payload byte): state -> GAP, pkt_done=1 for exactly that first GAP cycle.
- GAP:
  - data_ena=0, serial_data=0, byte_ready=0, busy=1.
  - Lasts GAP_CYCLES cycles, then state -> LOAD with count=0, busy=0.
- Latency: the first header bit appears on serial_data in the cycle after the edge that accepts the last payload byte.
- Packet period with continuous input = PAY_BYTES (load) + 8*(PAY_BYTES+1) + GAP_CYCLES cycles.
- Counters:
  - byte count is 4 bits.
  - bit count is 7 bits, sized for 8*9 = 72.
  - No wrap-around is possible within legal parameter ranges.
- Reset mid-operation aborts immediately and asynchronously: data_ena falls with reset_n, and buffered bytes are discarded.
- serial_data is 0 whenever data_ena is 0.

Test Plan:
- Reset then idle: hold reset_n low 3 cycles -> serial_data=0, data_ena=0, busy=0, byte_ready=1 after release.
- Basic packet: feed 0x12,0x34,0x56,0x78 on 4 consecutive cycles -> data_ena high 40 cycles, stream = A5 12 34 56 78 MSB first (first bits 1,0,1,0,0,1,0,1), then pkt_done pulse, then 4 cycles data_ena low.
- Stalled source: bytes 0xFF,0x00 with 10 idle cycles between each valid -> no SEND until 4th byte accepted; stream = A5 FF 00 <b2> <b3>.
- Backpressure: byte_valid held high with 0x3C through SEND and GAP -> byte_ready=0 throughout, byte accepted only in next LOAD, second packet = A5 3C 3C 3C 3C.
- Back-to-back packets: continuous valid for 8 bytes 0x01..0x08 -> two packets, exact gap of 4 cycles of data_ena=0 plus 4 load cycles between the last bit and the next header bit.
- Reset mid-SEND: assert reset_n low at bit 17 of a packet -> data_ena=0 immediately; after release, first new packet carries only newly supplied bytes.
